sorted_lists_upd_sched: RTL

//  Update scheduler in front of the sorted-lists table (M lists x N entries, keyed entries with size).

---
 rtl/sorted_lists_pkg.sv | 32 +++
 rtl/sorted_lists_rr_arb.sv | 27 ++
 rtl/sorted_lists_upd_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sorted_lists_pkg.sv
// Shared types for the sorted-lists table: list ids, table opcodes and the update command.
package sorted_lists_pkg;

  localparam int unsigned M      = 64;
  localparam int unsigned ID_W   = $clog2(M);
  localparam int unsigned KEY_W  = 16;
  localparam int unsigned SIZE_W = 8;

  typedef logic [ID_W-1:0]   list_id_t;
  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [SIZE_W-1:0] size_t;

  typedef enum logic [1:0] {
    OP_INSERT = 2'd0,
    OP_DELETE = 2'd1,
    OP_CLEAR  = 2'd2
  } op_t;

  typedef struct packed {
    op_t      op;
    list_id_t id;
    key_t     key;
    size_t    size;
  } cmd_t;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StDrain
  } sched_state_e;

endpackage

// File: rtl/sorted_lists_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr (purely combinational).
module sorted_lists_rr_arb #(
  parameter int unsigned R     = 4,
  parameter int unsigned PTR_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [R-1:0]     gnt
);

  logic found;

  // Search by rotation distance from ptr; the smallest distance with a request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < R; k++) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (!found && req[i] && (((i + R - 32'(ptr)) % R) == k)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sorted_lists_upd_sched.sv
// Update scheduler for the sorted-lists table: round-robin requester arbitration with list-id
// hazard blocking, registered command port, and the init/flush CLEAR sweep.
// Optional statistics counters: SORTED_LISTS_UPD_SCHED_STATS_EN.
module sorted_lists_upd_sched
  import sorted_lists_pkg::*;
#(
  parameter int unsigned R       = 4,
  parameter int unsigned RMW_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R-1:0]       req_vld,
  input  cmd_t [R-1:0]       req_cmd,
  output logic [R-1:0]       req_rdy,
  output logic               tbl_upd_vld,
  output cmd_t               tbl_upd_cmd,
  input  logic               tbl_upd_rdy,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy
`ifdef SORTED_LISTS_UPD_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_grants,
  output logic [31:0]        stat_hazard_stalls
`endif
);

  localparam int unsigned PTR_W = (R > 1) ? $clog2(R) : 1;

  sched_state_e     state_q, state_d;
  list_id_t         sweep_id_q, sweep_id_d;
  logic             flush_sweep_q, flush_sweep_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  cmd_t             cmd_q, cmd_d;
  logic             vld_q, vld_d;
  logic             flush_done_q, flush_done_d;
  logic [RMW_LAT-1:0] pipe_vld_q;
  list_id_t         pipe_id_q [RMW_LAT];

  logic         slot_free, accept, sweep_last;
  logic [R-1:0] hazard, arb_req, gnt;
  int unsigned  win;

  assign slot_free  = !vld_q || tbl_upd_rdy;
  assign accept     = vld_q && tbl_upd_rdy;
  assign sweep_last = accept && (sweep_id_q == list_id_t'(M - 1));

  // A list id is blocked while it sits in the command register or any in-flight stage.
  always_comb begin
    hazard = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (vld_q && cmd_q.id == req_cmd[i].id) hazard[i] = 1'b1;
      for (int unsigned s = 0; s < RMW_LAT; s++) begin
        if (pipe_vld_q[s] && pipe_id_q[s] == req_cmd[i].id) hazard[i] = 1'b1;
      end
    end
  end

  assign arb_req = (state_q == StRun && slot_free) ? (req_vld & ~hazard) : '0;

  sorted_lists_rr_arb #(
    .R     (R),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // One-hot grant to winner index.
  always_comb begin
    win = 0;
    for (int unsigned i = 0; i < R; i++) begin
      if (gnt[i]) win = i;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StInit;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (sweep_last) state_d = StRun;
      StRun:   if (flush) state_d = StDrain;
      StDrain: if (!vld_q && pipe_vld_q == '0) state_d = StInit;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_rdy = gnt;
    busy    = (state_q != StRun);
  end

  // Command register, sweep counter and round-robin pointer next-state.
  always_comb begin
    cmd_d         = cmd_q;
    vld_d         = accept ? 1'b0 : vld_q;
    sweep_id_d    = sweep_id_q;
    flush_sweep_d = flush_sweep_q;
    rr_ptr_d      = rr_ptr_q;
    flush_done_d  = 1'b0;
    unique case (state_q)
      StInit: begin
        if (accept) sweep_id_d = sweep_id_q + 1'b1;
        if (sweep_last) begin
          flush_done_d  = flush_sweep_q;
          flush_sweep_d = 1'b0;
        end else if (slot_free) begin
          // On acceptance the register must already hold the following id.
          vld_d      = 1'b1;
          cmd_d      = '0;
          cmd_d.op   = OP_CLEAR;
          cmd_d.id   = accept ? sweep_id_q + 1'b1 : sweep_id_q;
        end
      end
      StRun: begin
        if (gnt != '0) begin
          vld_d    = 1'b1;
          cmd_d    = req_cmd[win];
          rr_ptr_d = PTR_W'((win + 1) % R);
        end
      end
      StDrain: begin
        if (state_d == StInit) begin
          sweep_id_d    = '0;
          flush_sweep_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q         <= '0;
      vld_q         <= 1'b0;
      sweep_id_q    <= '0;
      flush_sweep_q <= 1'b0;
      rr_ptr_q      <= '0;
      flush_done_q  <= 1'b0;
    end else begin
      cmd_q         <= cmd_d;
      vld_q         <= vld_d;
      sweep_id_q    <= sweep_id_d;
      flush_sweep_q <= flush_sweep_d;
      rr_ptr_q      <= rr_ptr_d;
      flush_done_q  <= flush_done_d;
    end
  end

  // In-flight pipe: accepted ids age out after RMW_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int unsigned s = 0; s < RMW_LAT; s++) pipe_id_q[s] <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_id_q[0]  <= cmd_q.id;
      for (int unsigned s = 1; s < RMW_LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
    end
  end

  assign tbl_upd_vld = vld_q;
  assign tbl_upd_cmd = cmd_q;
  assign flush_done  = flush_done_q;

`ifdef SORTED_LISTS_UPD_SCHED_STATS_EN
  logic [31:0] grants_q, stalls_q;

  // Saturating grant and hazard-stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (gnt != '0 && grants_q != '1) grants_q <= grants_q + 1'b1;
      if (state_q == StRun && (req_vld & hazard) != '0 && stalls_q != '1) begin
        stalls_q <= stalls_q + 1'b1;
      end
    end
  end

  assign stat_grants        = grants_q;
  assign stat_hazard_stalls = stalls_q;
`endif

endmodule
